// File: rtl/irq_controller4_pkg.sv
// Shared definitions for the four-source interrupt controller.
//   irq_state_e  : handshake FSM states (IDLE / ASSERT / GAP)
//   IRQ_NUM_SRC  : number of request sources
//   IRQ_ID_W     : width of a source index
//   irq_onehot() : index -> one-hot source vector
package irq_pkg;

  localparam int unsigned IRQ_NUM_SRC = 4;
  localparam int unsigned IRQ_ID_W    = 2;

  typedef enum logic [1:0] {
    IRQ_IDLE   = 2'd0,
    IRQ_ASSERT = 2'd1,
    IRQ_GAP    = 2'd2
  } irq_state_e;

  function automatic logic [IRQ_NUM_SRC-1:0] irq_onehot(input logic [IRQ_ID_W-1:0] id);
    logic [IRQ_NUM_SRC-1:0] r;
    r     = '0;
    r[id] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/irq_controller4_if.sv
// Interrupt handshake between the controller and its consumer.
//   irq     : interrupt asserted to the consumer
//   irq_id  : index of the presented source, valid while irq=1
//   irq_ack : consumer acknowledge of the presented source
// master = controller side, slave = consumer side.
interface irq_controller4_if;
  import irq_pkg::*;

  logic                irq;
  logic [IRQ_ID_W-1:0] irq_id;
  logic                irq_ack;

  modport master (output irq, output irq_id, input irq_ack);
  modport slave  (input irq, input irq_id, output irq_ack);

endinterface

// File: rtl/irq_controller4_prienc.sv
// priority_encoder4x2: fixed-priority 4-to-2 encoder, highest index wins.
//   in    : request vector
//   out   : index of the highest set bit (0 when none set)
//   valid : at least one bit of in is set
module priority_encoder4x2 (
  input  logic [3:0] in,
  output logic [1:0] out,
  output logic       valid
);

  always_comb begin
    out   = '0;
    valid = |in;
    if (in[3])      out = 2'd3;
    else if (in[2]) out = 2'd2;
    else if (in[1]) out = 2'd1;
  end

endmodule

// File: rtl/irq_controller4.sv
// irq_controller4: four-source interrupt request controller.
// Synchronises asynchronous request lines, latches them as pending events,
// masks them, and presents the highest-index eligible source over an
// irq/irq_ack handshake with a one-cycle deassertion gap between interrupts.
//   clk, rst : clock, asynchronous active-high reset
//   req_in   : raw request lines (asynchronous)
//   mask     : per-source enable, 1 = may win
//   pending  : latched pending bits, unmasked view
//   bus      : irq / irq_id / irq_ack handshake (master side)
// Build option: IRQ_EDGE_DETECT_EN defined -> edge-triggered capture;
// undefined -> level capture.
module irq_controller4
  import irq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [IRQ_NUM_SRC-1:0] req_in,
  input  logic [IRQ_NUM_SRC-1:0] mask,
  output logic [IRQ_NUM_SRC-1:0] pending,
  irq_controller4_if.master      bus
);

  logic [IRQ_NUM_SRC-1:0] req_s;
  logic [IRQ_NUM_SRC-1:0] set_v;
  logic [IRQ_NUM_SRC-1:0] ack_clr;
  logic [IRQ_NUM_SRC-1:0] pend_q, pend_d;
  logic [IRQ_NUM_SRC-1:0] eligible;
  logic [IRQ_ID_W-1:0]    id_q, id_d;
  logic                   irq_q, irq_d;
  logic [IRQ_ID_W-1:0]    enc_out;
  logic                   enc_valid;
  irq_state_e             state_q, state_d;

  for (genvar i = 0; i < IRQ_NUM_SRC; i++) begin : g_sync
    logic [SYNC_STAGES-1:0] chain_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        chain_q <= '0;
      end else begin
        chain_q[0] <= req_in[i];
        for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
          chain_q[s] <= chain_q[s-1];
        end
      end
    end
    assign req_s[i] = chain_q[SYNC_STAGES-1];
  end

`ifdef IRQ_EDGE_DETECT_EN
  // The synchronisers come out of reset at 0, so a line held high through
  // reset would look like a fresh edge. Capture stays disabled until the
  // chain and the history register hold post-reset samples only.
  localparam logic [2:0] SETTLE_DONE = 3'(SYNC_STAGES + 1);

  logic [IRQ_NUM_SRC-1:0] req_hist_q;
  logic [2:0]             settle_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_hist_q <= '0;
      settle_q   <= '0;
    end else begin
      req_hist_q <= req_s;
      if (settle_q != SETTLE_DONE) settle_q <= settle_q + 3'd1;
    end
  end

  assign set_v = (settle_q == SETTLE_DONE) ? (req_s & ~req_hist_q) : '0;
`else
  assign set_v = req_s;
`endif

  assign eligible = pend_q & mask;

  priority_encoder4x2 u_enc (
    .in    (eligible),
    .out   (enc_out),
    .valid (enc_valid)
  );

  always_comb begin
    state_d = state_q;
    irq_d   = irq_q;
    id_d    = id_q;
    ack_clr = '0;
    case (state_q)
      IRQ_IDLE: begin
        irq_d = 1'b0;
        if (enc_valid) begin
          id_d    = enc_out;
          irq_d   = 1'b1;
          state_d = IRQ_ASSERT;
        end
      end
      IRQ_ASSERT: begin
        if (bus.irq_ack) begin
          ack_clr = irq_onehot(id_q);
          irq_d   = 1'b0;
          state_d = IRQ_GAP;
        end
      end
      IRQ_GAP: begin
        irq_d   = 1'b0;
        state_d = IRQ_IDLE;
      end
      default: begin
        irq_d   = 1'b0;
        state_d = IRQ_IDLE;
      end
    endcase
  end

  // Set is applied after clear so a same-cycle new event survives the ack.
  // In level mode this also keeps a still-active line pending.
  assign pend_d = (pend_q & ~ack_clr) | set_v;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IRQ_IDLE;
      irq_q   <= 1'b0;
      id_q    <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      irq_q   <= irq_d;
      id_q    <= id_d;
      pend_q  <= pend_d;
    end
  end

  assign bus.irq    = irq_q;
  assign bus.irq_id = id_q;
  assign pending    = pend_q;

endmodule

// File: tb/tb_irq_controller4.sv
`timescale 1ns/1ps
module tb_irq_controller4;
  import irq_pkg::*;

  localparam int unsigned S = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req_in = '0;
  logic [3:0] mask = '1;
  logic       ack = 1'b0;
  logic [3:0] pending;

  irq_controller4_if bus ();
  assign bus.irq_ack = ack;

  irq_controller4 #(.SYNC_STAGES(S)) dut (
    .clk     (clk),
    .rst     (rst),
    .req_in  (req_in),
    .mask    (mask),
    .pending (pending),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: req_in samples since reset, pending set, and a
  // presented/gap view of the handshake.
  logic [3:0]  hist[$];
  int unsigned nsamp;
  logic [3:0]  m_pend;
  logic        m_irq;
  logic        m_gap;
  logic [1:0]  m_id;

  task automatic model_reset();
    hist.delete();
    nsamp  = 0;
    m_pend = '0;
    m_irq  = 1'b0;
    m_gap  = 1'b0;
    m_id   = '0;
  endtask

  task automatic model_step();
    logic [3:0] cur, prv, setv, clr, elig;
    // Synchronised value seen at this edge = req_in sampled S edges earlier.
    cur = (nsamp >= S)     ? hist[hist.size() - S]     : 4'b0000;
    prv = (nsamp >= S + 1) ? hist[hist.size() - S - 1] : 4'b0000;
`ifdef IRQ_EDGE_DETECT_EN
    setv = (nsamp >= S + 1) ? (cur & ~prv) : 4'b0000;
`else
    setv = cur;
`endif
    clr  = '0;
    elig = m_pend & mask;
    if (m_irq) begin
      if (ack) begin
        clr[m_id] = 1'b1;
        m_irq     = 1'b0;
        m_gap     = 1'b1;
      end
    end else if (m_gap) begin
      m_gap = 1'b0;
    end else if (elig != 4'b0000) begin
      m_irq = 1'b1;
      for (int b = 0; b < 4; b++) if (elig[b]) m_id = 2'(b);
    end
    m_pend = (m_pend & ~clr) | setv;
    hist.push_back(req_in);
    if (hist.size() > 8) void'(hist.pop_front());
    if (nsamp < 100) nsamp++;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_step();
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    model_reset();
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    req_in = 4'b1111;
    mask   = 4'b1111;
    ack    = 1'b0;
    rst    = 1'b1;
    model_reset();
    repeat (3) tick();
    total++; if (bus.irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", bus.irq); end
    total++; if (bus.irq_id !== 2'd0) begin bad++; $display("FAIL reset_id got=%0d exp=0", bus.irq_id); end
    total++; if (pending !== 4'b0000) begin bad++; $display("FAIL reset_pending got=%b exp=0000", pending); end
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
`ifdef IRQ_EDGE_DETECT_EN
      total++; if (bus.irq !== 1'b0) begin bad++; $display("FAIL reset_steady_high cyc=%0d irq got=%b exp=0", c, bus.irq); end
`endif
      total++;
      if (bus.irq !== m_irq || (m_irq && bus.irq_id !== m_id) || pending !== m_pend) begin
        bad++;
        $display("FAIL reset_release cyc=%0d got irq=%b id=%0d pend=%b exp irq=%b id=%0d pend=%b",
                 c, bus.irq, bus.irq_id, pending, m_irq, m_id, m_pend);
      end
    end
  endtask

  task automatic test_single();
    req_in = '0; mask = 4'b1111; ack = 1'b0;
    apply_reset();
    repeat (6) tick();
    req_in = 4'b0100;
    tick();                       // edge 0
    req_in = 4'b0000;
    tick();                       // edge 1
    tick();                       // edge 2
    total++; if (pending !== 4'b0100) begin bad++; $display("FAIL single_pending got=%b exp=0100", pending); end
    total++; if (bus.irq !== 1'b0) begin bad++; $display("FAIL single_irq_early got=%b exp=0", bus.irq); end
    tick();                       // edge 3
    total++; if (bus.irq !== 1'b1 || bus.irq_id !== 2'd2) begin bad++; $display("FAIL single_irq got irq=%b id=%0d exp irq=1 id=2", bus.irq, bus.irq_id); end
    tick();
    total++; if (bus.irq !== 1'b1 || bus.irq_id !== 2'd2) begin bad++; $display("FAIL single_hold got irq=%b id=%0d exp irq=1 id=2", bus.irq, bus.irq_id); end
    ack = 1'b1;
    tick();                       // ack edge k
    ack = 1'b0;
    total++; if (bus.irq !== 1'b0 || pending !== 4'b0000) begin bad++; $display("FAIL single_ack got irq=%b pend=%b exp irq=0 pend=0000", bus.irq, pending); end
    tick();
    total++; if (bus.irq !== 1'b0) begin bad++; $display("FAIL single_gap1 got=%b exp=0", bus.irq); end
    tick();
    total++; if (bus.irq !== 1'b0) begin bad++; $display("FAIL single_gap2 got=%b exp=0", bus.irq); end
  endtask

  task automatic test_priority();
    int   ids[$];
    logic prev_irq;
    int   no_gap;
    req_in = '0; mask = 4'b1111; ack = 1'b0;
    apply_reset();
    repeat (6) tick();
    ack    = 1'b1;
    req_in = 4'b1011;
    tick();
    req_in = 4'b0000;
    prev_irq = 1'b0;
    no_gap   = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      total++;
      if (bus.irq !== m_irq || (m_irq && bus.irq_id !== m_id) || pending !== m_pend) begin
        bad++;
        $display("FAIL prio_model cyc=%0d got irq=%b id=%0d pend=%b exp irq=%b id=%0d pend=%b",
                 c, bus.irq, bus.irq_id, pending, m_irq, m_id, m_pend);
      end
      if (bus.irq === 1'b1) begin
        ids.push_back(int'(bus.irq_id));
        if (prev_irq === 1'b1) no_gap++;
      end
      prev_irq = bus.irq;
    end
    ack = 1'b0;
    total++; if (no_gap != 0) begin bad++; $display("FAIL prio_gap got=%0d back-to-back cycles exp=0", no_gap); end
    total++;
    if (ids.size() != 3 || ids[0] != 3 || ids[1] != 1 || ids[2] != 0) begin
      bad++;
      $display("FAIL prio_order got n=%0d first=%0d exp n=3 order 3,1,0", ids.size(), (ids.size() > 0) ? ids[0] : -1);
    end
  endtask

  task automatic test_mask();
    req_in = '0; mask = 4'b0111; ack = 1'b0;
    apply_reset();
    repeat (6) tick();
    req_in = 4'b1000;
    tick();
    req_in = 4'b0000;
    repeat (6) tick();
    total++; if (pending !== 4'b1000 || bus.irq !== 1'b0) begin bad++; $display("FAIL mask_hold got pend=%b irq=%b exp pend=1000 irq=0", pending, bus.irq); end
    mask = 4'b1111;
    for (int c = 0; c < 2; c++) begin
      tick();
      total++;
      if (bus.irq !== m_irq || (m_irq && bus.irq_id !== m_id) || pending !== m_pend) begin
        bad++;
        $display("FAIL mask_model cyc=%0d got irq=%b id=%0d exp irq=%b id=%0d", c, bus.irq, bus.irq_id, m_irq, m_id);
      end
    end
    total++; if (bus.irq !== 1'b1 || bus.irq_id !== 2'd3) begin bad++; $display("FAIL mask_release got irq=%b id=%0d exp irq=1 id=3", bus.irq, bus.irq_id); end
  endtask

  task automatic test_stability();
    req_in = '0; mask = 4'b1111; ack = 1'b0;
    apply_reset();
    repeat (6) tick();
    req_in = 4'b0010;
    tick();
    req_in = 4'b0000;
    for (int c = 0; c < 10 && bus.irq !== 1'b1; c++) tick();
    total++; if (bus.irq !== 1'b1 || bus.irq_id !== 2'd1) begin bad++; $display("FAIL stab_first got irq=%b id=%0d exp irq=1 id=1", bus.irq, bus.irq_id); end
    req_in = 4'b1000;
    tick();
    req_in = 4'b0000;
    for (int c = 0; c < 5; c++) begin
      tick();
      total++; if (bus.irq !== 1'b1 || bus.irq_id !== 2'd1) begin bad++; $display("FAIL stab_hold cyc=%0d got irq=%b id=%0d exp irq=1 id=1", c, bus.irq, bus.irq_id); end
    end
    total++; if (pending !== 4'b1010) begin bad++; $display("FAIL stab_pending got=%b exp=1010", pending); end
    // New edge on source 1 timed to be captured on the ack edge.
    req_in = 4'b0010;
    tick();
    req_in = 4'b0000;
    tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    total++; if (pending !== 4'b1010 || bus.irq !== 1'b0) begin bad++; $display("FAIL stab_collision got pend=%b irq=%b exp pend=1010 irq=0", pending, bus.irq); end
    tick();
    tick();
    total++; if (bus.irq !== 1'b1 || bus.irq_id !== 2'd3) begin bad++; $display("FAIL stab_next got irq=%b id=%0d exp irq=1 id=3", bus.irq, bus.irq_id); end
  endtask

  task automatic test_reset_midop();
    req_in = '0; mask = 4'b1111; ack = 1'b0;
    apply_reset();
    repeat (6) tick();
    req_in = 4'b0100;
    tick();
    req_in = 4'b0000;
    for (int c = 0; c < 10 && bus.irq !== 1'b1; c++) tick();
    total++; if (bus.irq !== 1'b1) begin bad++; $display("FAIL midop_setup got irq=%b exp=1", bus.irq); end
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    total++;
    if (bus.irq !== 1'b0 || bus.irq_id !== 2'd0 || pending !== 4'b0000) begin
      bad++;
      $display("FAIL midop_async got irq=%b id=%0d pend=%b exp all 0", bus.irq, bus.irq_id, pending);
    end
    tick();
    rst = 1'b0;
    repeat (8) tick();
    total++; if (bus.irq !== 1'b0 || pending !== 4'b0000) begin bad++; $display("FAIL midop_lost got irq=%b pend=%b exp irq=0 pend=0000", bus.irq, pending); end
  endtask

  task automatic test_random();
    req_in = '0; mask = 4'b1111; ack = 1'b0;
    apply_reset();
    repeat (6) tick();
    for (int c = 0; c < 500; c++) begin
      if ($urandom_range(0, 3) == 0) req_in = 4'($urandom);
      if ($urandom_range(0, 9) == 0) mask = 4'($urandom);
      ack = ($urandom_range(0, 2) == 0);
      tick();
      total++;
      if (bus.irq !== m_irq || (m_irq && bus.irq_id !== m_id) || pending !== m_pend) begin
        bad++;
        $display("FAIL random cyc=%0d got irq=%b id=%0d pend=%b exp irq=%b id=%0d pend=%b",
                 c, bus.irq, bus.irq_id, pending, m_irq, m_id, m_pend);
      end
    end
    ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_mask();
    test_stability();
    test_reset_midop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/irq_controller4.md
# irq_controller4

Four-source interrupt request controller that sits directly upstream of `priority_encoder4x2`. It synchronises four asynchronous request lines and latches them as pending events. It applies a per-source enable mask and presents one winning source at a time to a consumer over an assert/acknowledge handshake. Arbitration is fixed priority, highest index wins, and uses the existing 4-to-2 priority encoder.

## Interface
- `SYNC_STAGES`, default 2: flip-flop stages per request synchroniser; legal range 1..3.
- `clk`  input  1  sole clock, rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `req_in`  input  4  raw request lines, asynchronous to `clk`.
- `mask`  input  4  per-source enable; 1 = source may win; synchronous to `clk`.
- `irq_ack`  input  1  consumer acknowledge for the presented source.
- `irq`  output  1  interrupt asserted to the consumer.
- `irq_id`  output  2  index of the presented source; valid while `irq`=1.
- `pending`  output  4  latched pending bits, unmasked view.

## Operation
- Reset (async, `rst`=1): synchronisers, edge-history register, `pending`, state, `irq`, and `irq_id` all clear to 0. State is IDLE. Reset asserted mid-handshake drops `irq` immediately and loses all pending events.
- Synchroniser: each `req_in[i]` passes through `SYNC_STAGES` flops to give `req_s[i]`.
- Event capture: `pending[i]` sets on a 0→1 transition of `req_s[i]`. A bit clears only when it is acknowledged. If set and clear hit the same bit in the same cycle, set wins and no event is lost.
- Arbitration: `pending & mask` feeds `priority_encoder4x2`. Its `valid` output means at least one eligible source. Its `out` output is the highest eligible index.
- FSM states:
  - IDLE: `irq`=0. If the encoder's `valid`=1, register `irq_id` = encoder `out` and go to ASSERT.
  - ASSERT: `irq`=1 and `irq_id` held stable. Changes to `mask` or `pending` do not alter `irq_id`. On `irq_ack`=1, clear `pending[irq_id]` and go to GAP.
  - GAP: `irq`=0 for exactly one cycle, then IDLE. This guarantees a visible deassertion between back-to-back interrupts.
- `irq_ack` is ignored in IDLE and GAP.
- A masked pending bit stays pending indefinitely and becomes eligible once unmasked.
- A repeated edge on a source whose bit is already pending is absorbed; there is no counting.

## Timing
- `req_in` rises before edge 0: `pending` sets after edge `SYNC_STAGES`, and `irq` rises after edge `SYNC_STAGES`+1. For `SYNC_STAGES`=2: `pending` after edge 2, `irq` after edge 3.
- Ack sampled at edge k in ASSERT:
  - `irq`=0 and the `pending` bit cleared after edge k.
  - GAP during cycle k+1.
  - The next winner's `irq` rises after edge k+2 at the earliest.
- `irq_id` and `irq` are registered outputs. `pending` is registered.
- `irq_ack` held high continuously acknowledges each new interrupt on its first ASSERT cycle.

## Configuration
- `IRQ_EDGE_DETECT_EN` defined: edge-triggered capture, as described above.
- Undefined: level mode.
  - `pending[i]` is set every cycle that `req_s[i]`=1.
  - The ack clear takes effect only if `req_s[i]`=0 in that cycle; otherwise the bit stays set and the source re-arbitrates after GAP.
  - The edge-history register is omitted.

## Structure
- Shared package `irq_pkg` holds:
  - FSM state encodings `IRQ_IDLE`, `IRQ_ASSERT`, `IRQ_GAP` (2-bit).
  - Source count constant `IRQ_NUM_SRC`=4.
  - Index width constant `IRQ_ID_W`=2.
- One sub-module is instantiated: `priority_encoder4x2`, for arbitration.
- The synchroniser is a generate loop inside this module, not a separate module.

## Test plan
- Reset: hold `rst`=1 with `req_in`=4'b1111 → `irq`=0, `irq_id`=0, `pending`=0. Release with `req_in` steady high → in edge mode, no interrupt fires.
- Single source, `SYNC_STAGES`=2, `mask`=4'b1111: `req_in` 0→4'b0100 → `pending`=4'b0100 after edge 2; `irq`=1 with `irq_id`=2 after edge 3. Ack one cycle → `pending`=0, `irq`=0 for at least 2 cycles.
- Priority and ordering: `req_in` 0→4'b1011 in one cycle → interrupts are serviced in the order `irq_id` 3, 1, 0. Each is separated by one GAP cycle with `irq`=0.
- Masking: `mask`=4'b0111 with `req_in` rising on bit 3 → `pending`=4'b1000 and `irq`=0. Setting `mask`=4'b1111 → `irq`=1 with `irq_id`=3 two cycles later.
- Stability and collision: while ASSERT shows `irq_id`=1, raise source 3 → `irq_id` stays 1 until ack. Then a new rising edge on source 1 lands on the ack cycle → `pending[1]` remains 1.
- Reset mid-op: assert `rst` during ASSERT → `irq` drops asynchronously before the next clock edge, and all state clears.
